// File: rtl/neuron_pkg.sv
// Shared types for the time-multiplexed neuron scheduler: Q16.16 width,
// config field select codes, FSM states and the per-slot state record.
package neuron_pkg;

  localparam int Q_W = 32;

  typedef logic signed [Q_W-1:0] q16_t;

  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_I = 3'd4
  } cfg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    q16_t v, u, i, a, b, c, d;
  } neuron_t;

  typedef struct packed {
    logic v, u, i, a, b, c, d;
  } fmask_t;

  // Writing c resets the membrane (V), writing b resets the recovery (U).
  function automatic fmask_t cfg_mask(input logic [2:0] sel);
    fmask_t m;
    m = '0;
    case (cfg_sel_e'(sel))
      SEL_A: m.a = 1'b1;
      SEL_B: begin m.b = 1'b1; m.u = 1'b1; end
      SEL_C: begin m.c = 1'b1; m.v = 1'b1; end
      SEL_D: m.d = 1'b1;
      SEL_I: m.i = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/neuron_scheduler_if.sv
// Request/result link between the scheduler and the shared neuron update datapath.
interface neuron_scheduler_if #(
  parameter int IDX_W = 4
);
  import neuron_pkg::*;

  logic             DP_VALID;
  logic             DP_READY;
  logic [IDX_W-1:0] DP_IDX;
  logic [Q_W-1:0]   DP_V, DP_U, DP_I, DP_A, DP_B, DP_C, DP_D;
  logic             RES_VALID;
  logic [Q_W-1:0]   RES_V, RES_U;
  logic             RES_SPIKED;

  modport master (
    output DP_VALID, DP_IDX, DP_V, DP_U, DP_I, DP_A, DP_B, DP_C, DP_D,
    input  DP_READY, RES_VALID, RES_V, RES_U, RES_SPIKED
  );

  modport slave (
    input  DP_VALID, DP_IDX, DP_V, DP_U, DP_I, DP_A, DP_B, DP_C, DP_D,
    output DP_READY, RES_VALID, RES_V, RES_U, RES_SPIKED
  );
endinterface

// File: rtl/neuron_state_rf.sv
// Per-slot neuron state storage: one masked write port, one async read port.
module neuron_state_rf
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  fmask_t           i_wmask,
  input  neuron_t          i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output neuron_t          o_rdata
);

  neuron_t [NUM_NEURONS-1:0] w_all;

  for (genvar s = 0; s < NUM_NEURONS; s++) begin : g_slot
    neuron_t r_q;
    logic    w_hit;

    assign w_hit    = i_we && (i_widx == IDX_W'(s));
    assign w_all[s] = r_q;

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        r_q <= '0;
      end else if (w_hit) begin
        if (i_wmask.v) r_q.v <= i_wdata.v;
        if (i_wmask.u) r_q.u <= i_wdata.u;
        if (i_wmask.i) r_q.i <= i_wdata.i;
        if (i_wmask.a) r_q.a <= i_wdata.a;
        if (i_wmask.b) r_q.b <= i_wdata.b;
        if (i_wmask.c) r_q.c <= i_wdata.c;
        if (i_wmask.d) r_q.d <= i_wdata.d;
      end
    end
  end

  assign o_rdata = w_all[i_ridx];

endmodule

// File: rtl/neuron_scheduler.sv
// Walks every neuron slot through the shared update datapath once per TICK,
// one request outstanding at a time, and writes V/U back from the result.
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK,
  input  logic             CFG_WE,
  input  logic [IDX_W-1:0] CFG_IDX,
  input  logic [2:0]       CFG_SEL,
  input  logic [Q_W-1:0]   CFG_DATA,
  neuron_scheduler_if.master dp,
  output logic             SPIKE_VALID,
  output logic [IDX_W-1:0] SPIKE_IDX,
  output logic             BUSY,
  output logic             STEP_DONE,
  output logic             TICK_MISSED,
  output logic             CFG_ERR,
  output logic [15:0]      STEP_CNT
);

  state_e           r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_spike, r_tick_miss, r_cfg_err;
  logic [IDX_W-1:0] r_spike_idx;
  logic [15:0]      r_step_cnt;

  logic             w_cfg_ok, w_res, w_last, w_we;
  logic [IDX_W-1:0] w_widx;
  fmask_t           w_wmask;
  neuron_t          w_wdata, w_rd;

  assign w_cfg_ok = CFG_WE && (r_state == ST_IDLE) && (CFG_SEL <= 3'd4)
                    && (32'(CFG_IDX) < 32'(NUM_NEURONS));
  assign w_res    = dp.RES_VALID && (r_state == ST_WAIT);
  assign w_last   = (r_idx == IDX_W'(NUM_NEURONS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (TICK)         w_next = ST_ISSUE;
      ST_ISSUE: if (dp.DP_READY)  w_next = ST_WAIT;
      ST_WAIT:  if (dp.RES_VALID) w_next = w_last ? ST_DONE : ST_ISSUE;
      ST_DONE:                    w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  // Config and result writes share the port; they live in disjoint states.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = CFG_IDX;
    w_wmask = '0;
    w_wdata = neuron_t'({7{CFG_DATA}});
    if (w_res) begin
      w_we      = 1'b1;
      w_widx    = r_idx;
      w_wmask.v = 1'b1;
      w_wmask.u = 1'b1;
      w_wdata.v = dp.RES_V;
      w_wdata.u = dp.RES_U;
    end else if (w_cfg_ok) begin
      w_we    = 1'b1;
      w_wmask = cfg_mask(CFG_SEL);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_spike     <= 1'b0;
      r_spike_idx <= '0;
      r_tick_miss <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_step_cnt  <= '0;
    end else begin
      r_state     <= w_next;
      r_spike     <= w_res && dp.RES_SPIKED;
      r_spike_idx <= r_idx;
      r_tick_miss <= TICK && (r_state != ST_IDLE);
      r_cfg_err   <= CFG_WE && !w_cfg_ok;
      if (r_state == ST_IDLE && TICK)  r_idx <= '0;
      else if (w_res && !w_last)       r_idx <= r_idx + 1'b1;
      if (r_state == ST_DONE)          r_step_cnt <= r_step_cnt + 16'd1;
    end
  end

  neuron_state_rf #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) u_rf (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_we    (w_we),
    .i_widx  (w_widx),
    .i_wmask (w_wmask),
    .i_wdata (w_wdata),
    .i_ridx  (r_idx),
    .o_rdata (w_rd)
  );

  assign dp.DP_VALID = (r_state == ST_ISSUE);
  assign dp.DP_IDX   = r_idx;
  assign dp.DP_V     = w_rd.v;
  assign dp.DP_U     = w_rd.u;
  assign dp.DP_I     = w_rd.i;
  assign dp.DP_A     = w_rd.a;
  assign dp.DP_B     = w_rd.b;
  assign dp.DP_C     = w_rd.c;
  assign dp.DP_D     = w_rd.d;

  assign SPIKE_VALID = r_spike;
  assign SPIKE_IDX   = r_spike_idx;
  assign BUSY        = (r_state != ST_IDLE);
  assign STEP_DONE   = (r_state == ST_DONE);
  assign TICK_MISSED = r_tick_miss;
  assign CFG_ERR     = r_cfg_err;
  assign STEP_CNT    = r_step_cnt;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Randomized bench for neuron_scheduler: the bench plays the update datapath
// and keeps its own per-slot neuron table to predict every request and event.
module tb_neuron_scheduler;

  localparam int NN = 4;
  localparam int IW = 2;

  logic        clk, rst_n, tick, cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [2:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        SPIKE_VALID, BUSY, STEP_DONE, TICK_MISSED, CFG_ERR;
  logic [IW-1:0] SPIKE_IDX;
  logic [15:0] STEP_CNT;

  neuron_scheduler_if #(.IDX_W(IW)) dpif ();

  neuron_scheduler #(.NUM_NEURONS(NN), .IDX_W(IW)) dut (
    .CLK(clk), .RESET(rst_n), .TICK(tick), .CFG_WE(cfg_we), .CFG_IDX(cfg_idx),
    .CFG_SEL(cfg_sel), .CFG_DATA(cfg_data), .dp(dpif), .SPIKE_VALID(SPIKE_VALID),
    .SPIKE_IDX(SPIKE_IDX), .BUSY(BUSY), .STEP_DONE(STEP_DONE),
    .TICK_MISSED(TICK_MISSED), .CFG_ERR(CFG_ERR), .STEP_CNT(STEP_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference neuron table and step counter
  logic [31:0] mV [NN], mU [NN], mI [NN], mA [NN], mB [NN], mC [NN], mD [NN];
  logic [15:0] mcnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NN; k++) begin
      mV[k] = '0; mU[k] = '0; mI[k] = '0; mA[k] = '0;
      mB[k] = '0; mC[k] = '0; mD[k] = '0;
    end
    mcnt = '0;
  endtask

  task automatic model_cfg(input int idx, input int sel, input logic [31:0] d);
    case (sel)
      0: mA[idx] = d;
      1: begin mB[idx] = d; mU[idx] = d; end
      2: begin mC[idx] = d; mV[idx] = d; end
      3: mD[idx] = d;
      4: mI[idx] = d;
      default: ;
    endcase
  endtask

  // One time step: bench answers requests, checks payload/order/events per cycle.
  // inject_cyc >= 2 : TICK+CFG_WE mid-step; -2 : TICK+CFG_WE in the DONE cycle.
  // abort_slot      : assert reset when the DUT waits on that slot (done_cyc=-2).
  task automatic run_step(input int stall_slot, input int stall_len, input logic [3:0] spk,
                          input int dly_max, input int inject_cyc, input int abort_slot,
                          output int done_cyc);
    int cyc, slot, stalled, wait_left, spk_idx;
    bit in_wait, hs, exp_spk, exp_valid, exp_evt;
    logic [31:0] rv, ru;
    done_cyc = -1; slot = 0; stalled = 0; wait_left = 0; spk_idx = 0;
    in_wait = 0; hs = 0; exp_spk = 0;
    tick = 1'b1;
    step();
    tick = 1'b0; cfg_we = 1'b0;
    cyc = 2;
    while (cyc < 200) begin
      n_chk++;
      if (SPIKE_VALID !== exp_spk || (exp_spk && SPIKE_IDX !== IW'(spk_idx))) begin
        n_fail++;
        $display("FAIL spike cyc=%0d: got valid=%0b idx=%0d, want valid=%0b idx=%0d",
                 cyc, SPIKE_VALID, SPIKE_IDX, exp_spk, spk_idx);
      end
      exp_spk = 1'b0;
      if (hs) begin
        hs = 1'b0; in_wait = 1'b1;
        wait_left = int'($urandom_range(dly_max, 0));
        if (slot == abort_slot) begin
          dpif.DP_READY = 1'b0; dpif.RES_VALID = 1'b0;
          rst_n = 1'b0; done_cyc = -2;
          return;
        end
      end
      exp_valid = !in_wait && (slot < NN);
      exp_evt   = (cyc == inject_cyc + 1);
      n_chk++;
      if (dpif.DP_VALID !== exp_valid) begin
        n_fail++;
        $display("FAIL dp_valid cyc=%0d slot=%0d: got %0b, want %0b", cyc, slot, dpif.DP_VALID, exp_valid);
      end
      n_chk++;
      if (STEP_DONE !== (slot == NN)) begin
        n_fail++;
        $display("FAIL step_done cyc=%0d: got %0b, want %0b", cyc, STEP_DONE, slot == NN);
      end
      n_chk++;
      if (TICK_MISSED !== exp_evt || CFG_ERR !== exp_evt) begin
        n_fail++;
        $display("FAIL midstep_flags cyc=%0d: got miss=%0b err=%0b, want %0b", cyc, TICK_MISSED, CFG_ERR, exp_evt);
      end
      if (slot == NN) begin
        done_cyc = cyc;
        break;
      end
      dpif.RES_VALID = 1'b0; dpif.RES_SPIKED = 1'b0; tick = 1'b0; cfg_we = 1'b0;
      dpif.DP_READY = 1'($urandom_range(1, 0));
      if (exp_valid && dpif.DP_VALID) begin
        n_chk++;
        if (dpif.DP_IDX !== IW'(slot) ||
            {dpif.DP_V, dpif.DP_U, dpif.DP_I, dpif.DP_A, dpif.DP_B, dpif.DP_C, dpif.DP_D} !==
            {mV[slot], mU[slot], mI[slot], mA[slot], mB[slot], mC[slot], mD[slot]}) begin
          n_fail++;
          $display("FAIL payload cyc=%0d: got idx=%0d vu=%h_%h iabcd=%h_%h_%h_%h_%h, want idx=%0d vu=%h_%h iabcd=%h_%h_%h_%h_%h",
                   cyc, dpif.DP_IDX, dpif.DP_V, dpif.DP_U, dpif.DP_I, dpif.DP_A, dpif.DP_B, dpif.DP_C, dpif.DP_D,
                   slot, mV[slot], mU[slot], mI[slot], mA[slot], mB[slot], mC[slot], mD[slot]);
        end
        // stray results while a request is pending must be ignored
        dpif.RES_VALID = 1'($urandom_range(1, 0));
        dpif.RES_SPIKED = 1'b1; dpif.RES_V = $urandom; dpif.RES_U = $urandom;
        if (slot == stall_slot && stalled < stall_len) begin
          dpif.DP_READY = 1'b0; stalled++;
        end else begin
          dpif.DP_READY = 1'b1; hs = 1'b1;
        end
      end else if (in_wait) begin
        if (wait_left == 0) begin
          rv = $urandom; ru = $urandom;
          dpif.RES_VALID = 1'b1; dpif.RES_V = rv; dpif.RES_U = ru; dpif.RES_SPIKED = spk[slot];
          mV[slot] = rv; mU[slot] = ru;
          exp_spk = spk[slot]; spk_idx = slot;
          in_wait = 1'b0; slot++;
        end else begin
          wait_left--;
        end
      end
      if (cyc == inject_cyc) begin
        tick = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_sel = 3'd0; cfg_data = $urandom;
      end
      step();
      cyc++;
    end
    dpif.RES_VALID = 1'b0; dpif.DP_READY = 1'b0; dpif.RES_SPIKED = 1'b0;
    if (done_cyc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL step_timeout: got no STEP_DONE within 200 cycles, want one");
      return;
    end
    mcnt = mcnt + 16'd1;
    if (inject_cyc == -2) begin
      tick = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_sel = 3'd0; cfg_data = $urandom;
    end
    step();
    tick = 1'b0; cfg_we = 1'b0;
    n_chk++;
    if (STEP_CNT !== mcnt || BUSY !== 1'b0 || STEP_DONE !== 1'b0 || SPIKE_VALID !== 1'b0 ||
        TICK_MISSED !== (inject_cyc == -2) || CFG_ERR !== (inject_cyc == -2)) begin
      n_fail++;
      $display("FAIL after_done: got cnt=%0d busy=%0b done=%0b spk=%0b miss=%0b err=%0b, want cnt=%0d busy=0 done=0 spk=0 miss=%0b err=%0b",
               STEP_CNT, BUSY, STEP_DONE, SPIKE_VALID, TICK_MISSED, CFG_ERR, mcnt,
               inject_cyc == -2, inject_cyc == -2);
    end
    step();
    n_chk++;
    if (BUSY !== 1'b0 || STEP_DONE !== 1'b0 || TICK_MISSED !== 1'b0) begin
      n_fail++;
      $display("FAIL no_queued_step: got busy=%0b done=%0b miss=%0b, want 0 0 0", BUSY, STEP_DONE, TICK_MISSED);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd1; cfg_sel = 3'd2; cfg_data = 32'h1234_0000;
    step(); step();
    n_chk++;
    if ({BUSY, STEP_DONE, TICK_MISSED, CFG_ERR, SPIKE_VALID, dpif.DP_VALID} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 000000",
               {BUSY, STEP_DONE, TICK_MISSED, CFG_ERR, SPIKE_VALID, dpif.DP_VALID});
    end
    n_chk++;
    if (STEP_CNT !== 16'd0 || dpif.DP_IDX !== '0 ||
        {dpif.DP_V, dpif.DP_U, dpif.DP_I, dpif.DP_A, dpif.DP_B, dpif.DP_C, dpif.DP_D} !== 224'd0) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d idx=%0d v=%h, want 0 0 0", STEP_CNT, dpif.DP_IDX, dpif.DP_V);
    end
    tick = 1'b0; cfg_we = 1'b0;
    model_clear();
    rst_n = 1'b1;
  endtask

  // Starts in the very cycle reset is released.
  task automatic test_latency();
    int d;
    run_step(-1, 0, 4'b0000, 0, -1, -1, d);
    n_chk++;
    if (d !== 10 || STEP_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL latency: got done_cycle=%0d cnt=%0d, want 10 1", d, STEP_CNT);
    end
  endtask

  task automatic test_config();
    int idx, sel, d;
    logic [31:0] data;
    bit err;
    for (int k = 0; k < 24; k++) begin
      idx = int'($urandom_range(NN - 1, 0)); sel = int'($urandom_range(7, 0)); data = $urandom;
      if (k == 22) begin idx = 3; sel = 2; data = 32'hFFBF_0000; end
      if (k == 23) begin idx = 3; sel = 1; data = 32'h0000_3333; end
      err = (sel > 4);
      cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_sel = 3'(sel); cfg_data = data;
      step();
      cfg_we = 1'b0;
      n_chk++;
      if (CFG_ERR !== err || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err k=%0d sel=%0d: got err=%0b busy=%0b, want err=%0b busy=0", k, sel, CFG_ERR, BUSY, err);
      end
      if (!err) model_cfg(idx, sel, data);
    end
    step();
    n_chk++;
    if (CFG_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_width: got %0b, want 0", CFG_ERR);
    end
    run_step(-1, 0, 4'b0000, 0, -1, -1, d);
  endtask

  task automatic test_cfg_with_tick();
    int d;
    logic [31:0] data;
    data = $urandom;
    cfg_we = 1'b1; cfg_idx = '0; cfg_sel = 3'd2; cfg_data = data;
    model_cfg(0, 2, data);
    run_step(-1, 0, 4'b0000, 0, -1, -1, d);
  endtask

  task automatic test_backpressure();
    int d;
    run_step(2, 5, 4'b0000, 0, -1, -1, d);
    n_chk++;
    if (d !== 15) begin
      n_fail++;
      $display("FAIL backpressure_latency: got done_cycle=%0d, want 15", d);
    end
  endtask

  task automatic test_spike();
    int d;
    run_step(-1, 0, 4'b0010, 1, -1, -1, d);
  endtask

  task automatic test_midstep();
    int d;
    run_step(-1, 0, 4'b1001, 0, 4, -1, d);
    run_step(-1, 0, 4'b0000, 0, 7, -1, d);
  endtask

  task automatic test_tick_at_done();
    int d;
    run_step(-1, 0, 4'b1000, 0, -2, -1, d);
  endtask

  task automatic test_reset_midstep();
    int d;
    run_step(-1, 0, 4'b0110, 0, -1, 2, d);
    n_chk++;
    if (d !== -2) begin
      n_fail++;
      $display("FAIL abort_reached: got %0d, want -2", d);
    end
    #1;
    n_chk++;
    if ({BUSY, STEP_DONE, TICK_MISSED, CFG_ERR, SPIKE_VALID, dpif.DP_VALID} !== 6'b0 ||
        STEP_CNT !== 16'd0 || dpif.DP_IDX !== '0 || dpif.DP_V !== 32'd0 || dpif.DP_U !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_midstep: got flags=%b cnt=%0d idx=%0d v=%h u=%h, want all 0",
               {BUSY, STEP_DONE, TICK_MISSED, CFG_ERR, SPIKE_VALID, dpif.DP_VALID},
               STEP_CNT, dpif.DP_IDX, dpif.DP_V, dpif.DP_U);
    end
    model_clear();
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_chk++;
      if (BUSY !== 1'b0 || STEP_DONE !== 1'b0 || SPIKE_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL post_abort k=%0d: got busy=%0b done=%0b spk=%0b, want 0 0 0", k, BUSY, STEP_DONE, SPIKE_VALID);
      end
    end
    run_step(-1, 0, 4'(($urandom)), 1, -1, -1, d);
  endtask

  task automatic test_random();
    int d, idx, sel;
    logic [31:0] data;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 3; k++) begin
        idx = int'($urandom_range(NN - 1, 0)); sel = int'($urandom_range(7, 0)); data = $urandom;
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_sel = 3'(sel); cfg_data = data;
        step();
        cfg_we = 1'b0;
        n_chk++;
        if (CFG_ERR !== (sel > 4)) begin
          n_fail++;
          $display("FAIL rand_cfg sel=%0d: got %0b, want %0b", sel, CFG_ERR, sel > 4);
        end
        if (sel <= 4) model_cfg(idx, sel, data);
      end
      run_step(int'($urandom_range(NN - 1, 0)), int'($urandom_range(3, 0)), 4'($urandom),
               3, (s % 2 == 0) ? int'($urandom_range(8, 2)) : -1, -1, d);
    end
  endtask

  initial begin
    rst_n = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;
    dpif.DP_READY = 1'b0; dpif.RES_VALID = 1'b0; dpif.RES_V = '0; dpif.RES_U = '0;
    dpif.RES_SPIKED = 1'b0;
    mcnt = '0;
    test_reset();
    test_latency();
    test_config();
    test_cfg_with_tick();
    test_backpressure();
    test_spike();
    test_midstep();
    test_tick_at_done();
    test_reset_midstep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
